// File: rtl/tcam_match_reduce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcam_match_reduce: AND-reduces W/B partition match vectors per key and     |
// | priority-encodes them. Optional macro TCAM_MCOUNT_EN adds o_match_cnt.     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tcam_match_reduce #(
  parameter int W = 16,
  parameter int B = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [(2**B)-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_hit,
  output logic [B-1:0]      o_match_addr,
  output logic              o_multi_hit
`ifdef TCAM_MCOUNT_EN
  ,
  output logic [B:0]        o_match_cnt
`endif
);

  localparam int N  = 2**B;
  localparam int P  = W / B;
  localparam int KW = (P > 1) ? $clog2(P) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(P - 1);

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_ENC = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [N-1:0]    r_acc;
  logic            r_hit;
  logic [B-1:0]    r_addr;
  logic            r_multi;

  logic            w_beat;
  logic [N-1:0]    w_acc_next;
  logic [B-1:0]    w_addr;
  logic            w_multi;

  assign o_in_ready   = (r_state == S_ACC);
  assign o_out_valid  = (r_state == S_OUT);
  assign o_hit        = r_hit;
  assign o_match_addr = r_addr;
  assign o_multi_hit  = r_multi;

  assign w_beat     = i_in_valid & o_in_ready;
  assign w_acc_next = (r_k == '0) ? i_in_data : (r_acc & i_in_data);

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    w_addr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_acc[i]) begin
        w_addr = B'(i);
      end
    end
  end

`ifdef TCAM_MCOUNT_EN
  logic [B:0] r_cnt;
  logic [B:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt = w_cnt + (B+1)'(r_acc[i]);
    end
  end

  assign w_multi     = (w_cnt > (B+1)'(1));
  assign o_match_cnt = r_cnt;
`else
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(r_acc & (r_acc - {{(N-1){1'b0}}, 1'b1}));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACC;
      r_k     <= '0;
      r_acc   <= '0;
      r_hit   <= 1'b0;
      r_addr  <= '0;
      r_multi <= 1'b0;
`ifdef TCAM_MCOUNT_EN
      r_cnt   <= '0;
`endif
    end else if (i_flush) begin
      r_state <= S_ACC;
      r_k     <= '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            if (r_k == K_LAST) begin
              r_k     <= '0;
              r_state <= S_ENC;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_ENC: begin
          r_hit   <= |r_acc;
          r_addr  <= w_addr;
          r_multi <= w_multi;
`ifdef TCAM_MCOUNT_EN
          r_cnt   <= w_cnt;
`endif
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_state <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcam_match_reduce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tcam_match_reduce: randomized and directed bench for tcam_match_reduce |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_tcam_match_reduce;

  localparam int W = 16;
  localparam int B = 8;
  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_flush = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         i_out_ready = 1'b0;
  logic [N-1:0] i_in_data = '0;
  logic         o_in_ready;
  logic         o_out_valid;
  logic         o_hit;
  logic [B-1:0] o_match_addr;
  logic         o_multi_hit;
`ifdef TCAM_MCOUNT_EN
  logic [B:0]   o_match_cnt;
`endif

  tcam_match_reduce #(.W(W), .B(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (i_flush),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_hit        (o_hit),
    .o_match_addr (o_match_addr),
    .o_multi_hit  (o_multi_hit)
`ifdef TCAM_MCOUNT_EN
    ,
    .o_match_cnt  (o_match_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hit;
    int   addr;
    logic multi;
    int   cnt;
  } res_t;

  int           n_chk = 0;
  int           n_pass = 0;
  logic [N-1:0] part_q[$];
  res_t         exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: intersect the partitions, then count members and pick the smallest index.
  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    res_t         r;
    logic [N-1:0] m;
    logic         found;
    m = a & b;
    r.cnt = 0;
    r.addr = 0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        if (!found) r.addr = i;
        found = 1'b1;
        r.cnt++;
      end
    end
    r.hit = (r.cnt != 0);
    r.multi = (r.cnt >= 2);
    return r;
  endfunction

  function automatic logic [N-1:0] rvec();
    logic [N-1:0] v;
    int           m;
    m = $urandom_range(0, 3);
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom();
    case (m)
      0: begin
        v = '0;
        repeat ($urandom_range(1, 3)) v[$urandom_range(0, N - 1)] = 1'b1;
      end
      2: v = v | ({N{1'b1}} << $urandom_range(0, N - 1));
      3: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk_out(input string tag, input res_t e);
    chk({tag, ".hit"}, 32'(o_hit), 32'(e.hit));
    chk({tag, ".addr"}, 32'(o_match_addr), e.addr);
    chk({tag, ".multi"}, 32'(o_multi_hit), 32'(e.multi));
`ifdef TCAM_MCOUNT_EN
    chk({tag, ".cnt"}, 32'(o_match_cnt), e.cnt);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    res_t z;
    z.hit = 1'b0; z.addr = 0; z.multi = 1'b0; z.cnt = 0;
    chk({tag, ".rdy"}, 32'(o_in_ready), 1);
    chk({tag, ".ov"}, 32'(o_out_valid), 0);
    chk_out(tag, z);
  endtask

  // One cycle from a falling edge: drive, score against DUT handshakes, advance.
  task automatic step(input logic vld, input logic rdy, output logic took_out);
    logic beat;
    logic hs;
    i_in_valid  = vld;
    i_out_ready = rdy;
    i_in_data   = rvec();
    beat = vld && o_in_ready;
    hs   = o_out_valid && rdy;
    if (o_out_valid) begin
      if (exp_q.size() == 0) chk("sb.extra", 32'(o_out_valid), 0);
      else chk_out("sb", exp_q[0]);
    end
    if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
    if (beat) begin
      part_q.push_back(i_in_data);
      if (part_q.size() == 2) begin
        exp_q.push_back(model(part_q[0], part_q[1]));
        part_q.delete();
      end
    end
    took_out = hs;
    @(negedge clk);
  endtask

  // Starts and ends on a falling edge with the DUT idle in accumulate.
  task automatic run_key(input logic [N-1:0] v0, input logic [N-1:0] v1, input int hold);
    res_t e;
    e = model(v0, v1);
    chk("rk.rdy0", 32'(o_in_ready), 1);
    i_in_valid = 1'b1;
    i_in_data  = v0;
    @(negedge clk);
    chk("rk.rdy1", 32'(o_in_ready), 1);
    i_in_data = v1;
    @(negedge clk);
    i_in_valid = 1'b0;
    i_in_data  = '0;
    chk("rk.enc_ov", 32'(o_out_valid), 0);
    chk("rk.enc_rdy", 32'(o_in_ready), 0);
    @(negedge clk);
    chk("rk.ov", 32'(o_out_valid), 1);
    chk("rk.out_rdy", 32'(o_in_ready), 0);
    chk_out("rk", e);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("rk.hold_ov", 32'(o_out_valid), 1);
      chk("rk.hold_rdy", 32'(o_in_ready), 0);
      chk_out("rk.hold", e);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    chk("rk.done_ov", 32'(o_out_valid), 0);
    chk("rk.done_rdy", 32'(o_in_ready), 1);
    chk_out("rk.kept", e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] v0;
    logic [N-1:0] v1;
    logic         t;
    int           last;
    int           nres;

    #1;
    chk_reset_vals("rst_hold");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_rel");

    v0 = '0; v0[5] = 1'b1; v0[9] = 1'b1; v0[200] = 1'b1;
    v1 = '0; v1[9] = 1'b1; v1[200] = 1'b1;
    run_key(v0, v1, 0);
    chk("t1.addr", 32'(o_match_addr), 9);
    chk("t1.multi", 32'(o_multi_hit), 1);

    v0 = '0; v0[8'h8a] = 1'b1;
    v1 = '0; v1[8'hfb] = 1'b1;
    run_key(v0, v1, 0);
    chk("t2.hit", 32'(o_hit), 0);

    v0 = '1;
    v1 = '0; v1[8'hf1] = 1'b1;
    run_key(v0, v1, 5);
    chk("t3.addr", 32'(o_match_addr), 32'h0f1);

    last = -1;
    nres = 0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      step(1'b1, 1'b1, t);
      if (t) begin
        if (last >= 0) chk("b2b.gap", cyc - last, 4);
        last = cyc;
        nres++;
      end
    end
    i_in_valid = 1'b0;
    chk("b2b.count", nres, 12);
    chk("b2b.pend", exp_q.size() + part_q.size(), 0);

    for (int cyc = 0; cyc < 300; cyc++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, t);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (part_q.size() != 0 || exp_q.size() != 0) step(part_q.size() != 0, 1'b1, t);
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    chk("rnd.drain", exp_q.size() + part_q.size(), 0);

    v0 = '0; v0[3] = 1'b1;
    i_in_valid = 1'b1;
    i_in_data  = v0;
    @(negedge clk);
    i_flush   = 1'b1;
    i_in_data = '1;
    @(negedge clk);
    i_flush    = 1'b0;
    i_in_valid = 1'b0;
    chk("fl.rdy", 32'(o_in_ready), 1);
    v0 = '0; v0[7] = 1'b1;
    run_key(v0, v0, 0);
    chk("fl.addr", 32'(o_match_addr), 7);
    chk("fl.hit", 32'(o_hit), 1);

    v0 = '0; v0[100] = 1'b1; v0[101] = 1'b1;
    v1 = '0; v1[101] = 1'b1;
    i_in_valid = 1'b1;
    i_in_data  = v0;
    @(negedge clk);
    i_in_data = v1;
    @(negedge clk);
    i_in_valid = 1'b0;
    @(negedge clk);
    chk("flo.ov_before", 32'(o_out_valid), 1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flo.ov_after", 32'(o_out_valid), 0);
    chk("flo.rdy", 32'(o_in_ready), 1);
    chk("flo.hit_kept", 32'(o_hit), 1);
    chk("flo.addr_kept", 32'(o_match_addr), 101);

    v0 = '0; v0[4] = 1'b1;
    i_in_valid = 1'b1;
    i_in_data  = v0;
    @(negedge clk);
    i_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst = 1'b0;
    v0 = '0; v0[20] = 1'b1;
    v1 = '0; v1[20] = 1'b1; v1[30] = 1'b1;
    run_key(v0, v1, 0);
    chk("arst.addr", 32'(o_match_addr), 20);
    chk("arst.hit", 32'(o_hit), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tcam_match_reduce.md
# tcam_match_reduce

Downstream stage of the partitioned SRAM-based TCAM lookup. It consumes the per-partition match vectors produced by the bit-position table stage, one `2**b`-bit vector per `b`-bit sub-word of the `w`-bit search word. It AND-reduces the `w/b` vectors of one search key and priority-encodes the result into a registered hit / match-address / multi-hit result with a valid/ready handshake.

## Interface
Parameters:
- `w`, 16: search word width; must be a multiple of `b`.
- `b`, 8: sub-word width; match vector width is `N = 2**b`, address width is `b`.
- `P` (localparam), `w/b`: number of partition vectors per key; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous abort of the current key.
- `in_valid`  in  1: `in_data` holds one partition match vector.
- `in_ready`  out  1: block accepts a vector this cycle.
- `in_data`  in  `2**b`: partition match vector; bit i set means entry i matches this sub-word.
- `out_valid`  out  1: result registers valid.
- `out_ready`  in  1: consumer takes the result.
- `hit`  out  1: at least one entry matched all partitions.
- `match_addr`  out  `b`: lowest index of a fully matching entry; 0 when `hit`=0.
- `multi_hit`  out  1: two or more entries matched all partitions.
- `match_cnt`  out  `b+1`: number of fully matching entries. Present only with `TCAM_MCOUNT_EN`.

## Operation
- Internal state: `acc[N-1:0]`, beat counter `k` (0..P-1) and FSM state in {ACC, ENC, OUT}.
- ACC state:
  - `in_ready`=1.
  - On a beat (`in_valid & in_ready`):
    - `k==0`: `acc <= in_data`.
    - otherwise: `acc <= acc & in_data`.
  - If `k==P-1`: `k <= 0` and go to ENC. Otherwise `k <= k+1`.
  - With P=1 every beat goes straight to ENC.
- ENC state:
  - `in_ready`=0.
  - Registers `hit = |acc`, `match_addr` = index of lowest set bit of `acc` (0 if none), and `multi_hit` = more than one bit set.
  - Goes to OUT unconditionally.
- OUT state:
  - `in_ready`=0, `out_valid`=1.
  - Result outputs are held stable until `out_ready`=1, then go to ACC.
  - Result registers keep their values after the handshake; only `out_valid` drops.
- `flush`:
  - Overrides everything in the same cycle: next state ACC, `k <= 0`, `out_valid` drops.
  - A beat presented with `flush`=1 is discarded.
  - Result registers are not cleared.
- All-zero vector at any beat: that key yields `hit`=0, `match_addr`=0, `multi_hit`=0.
- All-ones `acc`: `match_addr`=0, `multi_hit`=1.

## Timing
- Reset values:
  - state ACC, `k`=0, `acc`=0.
  - `in_ready`=1, `out_valid`=0.
  - `hit`=0, `match_addr`=0, `multi_hit`=0, `match_cnt`=0.
- `in_ready` and `out_valid` are decoded combinationally from the state register only, never from inputs.
- Latency: the last beat is accepted at edge E. ENC is active in the cycle after E. `out_valid` goes high after edge E+1 and is seen in the second cycle after the last beat.
- Throughput: at most one key per P+2 cycles (P beats, ENC, one OUT cycle with `out_ready`=1).
- Backpressure: OUT persists indefinitely while `out_ready`=0. No new beats are accepted until the handshake completes, so no result is ever overwritten.
- `out_ready` has no effect outside OUT.
- Reset mid-operation: immediate return to reset values. A partial key is lost.

## Configuration
- `TCAM_MCOUNT_EN` defined:
  - `match_cnt` port exists.
  - It is registered in ENC as the popcount of `acc` (0..N, width `b+1`), with the same timing and hold behaviour as `hit`.
  - `multi_hit` must equal `match_cnt > 1`.
- `TCAM_MCOUNT_EN` undefined: `match_cnt` port and popcount logic are absent. All other behaviour is identical.

## Test plan
All scenarios use defaults `w`=16, `b`=8 (P=2, N=256).
- Reset, then two beats: bits {5,9,200} set, then bits {9,200}.
  - Expect `out_valid` in the 2nd cycle after the second beat.
  - Expect `hit`=1, `match_addr`=9, `multi_hit`=1; `match_cnt`=2 with the macro.
- Beats: bit 0x8a set, then bit 0xfb set.
  - Expect `hit`=0, `match_addr`=0, `multi_hit`=0.
- Beats: all-ones, then only bit 0xf1 set; hold `out_ready`=0 for 5 cycles.
  - Expect outputs stable at `hit`=1, `match_addr`=0xf1, `multi_hit`=0, and `in_ready`=0 throughout.
  - After `out_ready`=1: `out_valid` drops the next cycle and `in_ready`=1.
- Back-to-back keys with `in_valid` held high and `out_ready` tied high.
  - Expect exactly one result per 4 cycles, in order, each result matching its own pair of vectors.
- Flush after the first beat (bit 3 set), then a fresh pair: bit 7, bit 7.
  - Expect the single result `match_addr`=7; bit 3 never influences it.
  - Also check `flush` asserted in OUT clears `out_valid`.
- Assert `rst` asynchronously between edges after one beat.
  - Expect all outputs at reset values immediately, with no clock needed.
  - The next two beats form a complete new key.
